// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : Single-issue ALU plus iterative multiply/divide unit.
//                ALU ops complete in one cycle; MULT/MULTU use one shift-add
//                step per cycle, DIV/DIVU one restoring step per cycle.
//                Optional divider compiled in with macro ALU_MDU_DIV_EN;
//                without it DIV/DIVU behave as reserved opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             div_by_zero_o
);

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_OR    = 4'd2;
  localparam logic [3:0] c_OP_AND   = 4'd3;
  localparam logic [3:0] c_OP_XOR   = 4'd4;
  localparam logic [3:0] c_OP_SLT   = 4'd5;
  localparam logic [3:0] c_OP_SLTU  = 4'd6;
  localparam logic [3:0] c_OP_MULT  = 4'd7;
  localparam logic [3:0] c_OP_MULTU = 4'd8;

`ifdef ALU_MDU_DIV_EN
  localparam logic [3:0] c_OP_DIV   = 4'd9;
  localparam logic [3:0] c_OP_DIVU  = 4'd10;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_e;
`endif

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     result_q, hi_q, lo_q;
  logic                 zero_q, ovf_q, dbz_q;
  logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q;
  logic                 msigned_q;

  logic [WIDTH-1:0]     w_sum, w_diff, w_alu_res;
  logic                 w_alu_ovf, w_alu_op, w_last, w_is_mul;

  assign w_sum    = a_i + b_i;
  assign w_diff   = a_i - b_i;
  assign w_alu_op = (op_i <= c_OP_SLTU);
  assign w_is_mul = (op_i == c_OP_MULT) || (op_i == c_OP_MULTU);
  assign w_last   = (cnt_q == CNT_W'(WIDTH - 1));

  // Single-cycle ALU result and signed overflow from the live operands
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (op_i)
      c_OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      c_OP_OR:   w_alu_res = a_i | b_i;
      c_OP_AND:  w_alu_res = a_i & b_i;
      c_OP_XOR:  w_alu_res = a_i ^ b_i;
      c_OP_SLT:  w_alu_res = WIDTH'($signed(a_i) < $signed(b_i));
      c_OP_SLTU: w_alu_res = WIDTH'(a_i < b_i);
      default:   w_alu_res = '0;
    endcase
  end

  // Shift-add step; the multiplier MSB carries negative weight for signed MULT
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      if (msigned_q && w_last) acc_d = acc_q - mcand_q;
      else                     acc_d = acc_q + mcand_q;
    end
  end

`ifdef ALU_MDU_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, w_abs_a, w_abs_b, w_q_fix, w_r_fix;
  logic [WIDTH:0]   w_rem_sh, w_trial;
  logic             negq_q, negr_q, w_sdiv, w_is_div;

  assign w_sdiv   = (op_i == c_OP_DIV);
  assign w_is_div = (op_i == c_OP_DIV) || (op_i == c_OP_DIVU);
  assign w_abs_a  = (w_sdiv && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_abs_b  = (w_sdiv && b_i[WIDTH-1]) ? -b_i : b_i;

  // Restoring division step on magnitudes, then sign fix-up of the final pair
  always_comb begin
    w_rem_sh = {rem_q, quo_q[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, dvs_q};
    if (!w_trial[WIDTH]) begin
      rem_d = w_trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = w_rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    w_q_fix = negq_q ? -quo_d : quo_d;
    w_r_fix = negr_q ? -rem_d : rem_d;
  end
`endif

  // Control FSM, iteration datapath and held result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      msigned_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (w_is_mul) begin
              msigned_q <= (op_i == c_OP_MULT);
              mcand_q   <= (op_i == c_OP_MULT) ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
              mplier_q  <= b_i;
              acc_q     <= '0;
              state_q   <= S_MUL;
            end
`ifdef ALU_MDU_DIV_EN
            else if (w_is_div) begin
              if (b_i == '0) begin
                result_q <= '1;
                lo_q     <= '1;
                hi_q     <= a_i;
                zero_q   <= 1'b0;
                ovf_q    <= 1'b0;
                dbz_q    <= 1'b1;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                negq_q  <= w_sdiv && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                negr_q  <= w_sdiv && a_i[WIDTH-1];
                quo_q   <= w_abs_a;
                dvs_q   <= w_abs_b;
                rem_q   <= '0;
                state_q <= S_DIV;
              end
            end
`endif
            else begin
              // ALU ops and reserved opcodes; hi/lo are left untouched
              result_q <= w_alu_res;
              zero_q   <= w_alu_op && (w_alu_res == '0);
              ovf_q    <= w_alu_ovf;
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (w_last) begin
            cnt_q    <= '0;
            hi_q     <= acc_d[2*WIDTH-1:WIDTH];
            lo_q     <= acc_d[WIDTH-1:0];
            result_q <= acc_d[WIDTH-1:0];
            zero_q   <= (acc_d[WIDTH-1:0] == '0);
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
`ifdef ALU_MDU_DIV_EN
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (w_last) begin
            cnt_q    <= '0;
            lo_q     <= w_q_fix;
            hi_q     <= w_r_fix;
            result_q <= w_q_fix;
            zero_q   <= (w_q_fix == '0);
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign zero_o        = zero_q;
  assign overflow_o    = ovf_q;
  assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mdu
//  Description : Directed self-checking bench for alu_mdu (WIDTH=32) with a
//                cycle-level reference model and literal spot checks.
//                Honours ALU_MDU_DIV_EN the same way the design does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

  localparam logic [3:0] c_ADD = 4'd0, c_SUB = 4'd1, c_OR = 4'd2, c_AND = 4'd3;
  localparam logic [3:0] c_XOR = 4'd4, c_SLT = 4'd5, c_SLTU = 4'd6;
  localparam logic [3:0] c_MULT = 4'd7, c_MULTU = 4'd8, c_DIV = 4'd9, c_DIVU = 4'd10;

  logic        clk, rst_n, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, ovf, dbz;
  logic [31:0] result, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  bit          m_active = 0;
  int          m_start_cyc = 0, m_done_cyc = 0;
  logic [31:0] p_res, p_hi, p_lo;
  bit          p_z, p_ov, p_dz;
  logic [31:0] e_res = 0, e_hi = 0, e_lo = 0;
  bit          e_z = 0, e_ov = 0, e_dz = 0, e_busy, e_done;

  alu_mdu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .hi_o(hi), .lo_o(lo),
    .zero_o(zero), .overflow_o(ovf), .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Compute what an accepted request must produce, straight from the op rules
  task automatic model_issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, s, q, r;
    logic [63:0] pu;
    bit rsv;
    int lat;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rsv = 0; lat = 0;
    p_hi = e_hi; p_lo = e_lo; p_res = 0; p_ov = 0; p_dz = 0;
    case (o)
      c_ADD:  begin s = sx + sy; p_res = x + y; p_ov = (s != longint'($signed(p_res))); end
      c_SUB:  begin s = sx - sy; p_res = x - y; p_ov = (s != longint'($signed(p_res))); end
      c_OR:   p_res = x | y;
      c_AND:  p_res = x & y;
      c_XOR:  p_res = x ^ y;
      c_SLT:  p_res = (sx < sy) ? 32'd1 : 32'd0;
      c_SLTU: p_res = (x < y) ? 32'd1 : 32'd0;
      c_MULT: begin s = sx * sy; p_hi = s[63:32]; p_lo = s[31:0]; p_res = p_lo; lat = 32; end
      c_MULTU: begin pu = {32'd0, x} * {32'd0, y}; p_hi = pu[63:32]; p_lo = pu[31:0]; p_res = p_lo; lat = 32; end
`ifdef ALU_MDU_DIV_EN
      c_DIV, c_DIVU: begin
        if (y == 0) begin
          p_lo = 32'hFFFF_FFFF; p_hi = x; p_dz = 1;
        end else begin
          if (o == c_DIV) begin q = sx / sy; r = sx % sy; end
          else begin q = longint'({32'd0, x}) / longint'({32'd0, y}); r = longint'({32'd0, x}) % longint'({32'd0, y}); end
          p_lo = q[31:0]; p_hi = r[31:0]; lat = 32;
        end
        p_res = p_lo;
      end
`endif
      default: rsv = 1;
    endcase
    p_z = !rsv && (p_res == 0);
    m_start_cyc = cyc + 1;
    m_done_cyc  = cyc + 1 + lat;
    m_active    = 1;
  endtask

  task automatic model_reset();
    m_active = 0;
    e_res = 0; e_hi = 0; e_lo = 0; e_z = 0; e_ov = 0; e_dz = 0;
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_active && cyc == m_done_cyc) begin
      e_res = p_res; e_hi = p_hi; e_lo = p_lo; e_z = p_z; e_ov = p_ov; e_dz = p_dz;
    end
    e_busy = m_active && (cyc >= m_start_cyc) && (cyc <= m_done_cyc);
    e_done = m_active && (cyc == m_done_cyc);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("result", result, e_res);
    chk("hi", hi, e_hi);
    chk("lo", lo, e_lo);
    chk("zero", zero, e_z);
    chk("overflow", ovf, e_ov);
    chk("div_by_zero", dbz, e_dz);
  end

  // Issue one request, scramble inputs while busy, return just after done cycle
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit poke_busy, output int n);
    @(negedge clk);
    model_issue(o, x, y);
    start = 1; op = o; a = x; b = y;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = poke_busy && (n == 5);
      if (start) begin op = c_ADD; a = 32'd1; b = 32'd1; end
      else begin op = 4'($urandom_range(15)); a = $urandom; b = $urandom; end
    end while (cyc < m_done_cyc);
    #1;
  endtask

  // Start pulse during the DONE cycle; must be ignored
  task automatic poke_done();
    start = 1; op = c_ADD; a = 32'd7; b = 32'd8;
    @(negedge clk);
    start = 0;
  endtask

  int n;

  initial begin
    rst_n = 0; start = 0; op = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'd0);
    #1 rst_n = 1;

    run_op(c_ADD, 32'h7FFF_FFFF, 32'd1, 0, n);
    chk("add_lat", n, 1); chk("add_done", done, 1'b1);
    chk("add_res", result, 32'h8000_0000); chk("add_ovf", ovf, 1'b1); chk("add_zero", zero, 1'b0);
    run_op(c_SUB, 32'd5, 32'd5, 0, n);
    chk("sub_res", result, 32'd0); chk("sub_zero", zero, 1'b1);
    run_op(c_SLT, 32'hFFFF_FFFF, 32'd1, 0, n);
    chk("slt_res", result, 32'd1);
    run_op(c_SLTU, 32'hFFFF_FFFF, 32'd1, 0, n);
    chk("sltu_res", result, 32'd0);
    run_op(c_MULT, 32'hFFFF_FFFE, 32'd3, 1, n);
    chk("mult_lat", n, 33); chk("mult_done", done, 1'b1);
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n);
    chk("multu_hi", hi, 32'hFFFF_FFFE); chk("multu_lo", lo, 32'h0000_0001);
    poke_done();
`ifdef ALU_MDU_DIV_EN
    run_op(c_DIV, 32'hFFFF_FFF9, 32'd2, 0, n);
    chk("div_lat", n, 33); chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(c_DIVU, 32'd9, 32'd0, 0, n);
    chk("divz_lat", n, 1); chk("divz_lo", lo, 32'hFFFF_FFFF); chk("divz_hi", hi, 32'd9); chk("divz_flag", dbz, 1'b1);
    run_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
    chk("divmin_lo", lo, 32'h8000_0000); chk("divmin_hi", hi, 32'd0); chk("divmin_ovf", ovf, 1'b0);
    run_op(c_DIV, 32'd7, 32'hFFFF_FFFE, 0, n);
    run_op(c_DIVU, 32'd100, 32'd7, 0, n);
    run_op(c_DIV, 32'd0, 32'd5, 0, n);
`else
    run_op(c_DIV, 32'hFFFF_FFF9, 32'd2, 0, n);
    chk("rsvdiv_lat", n, 1); chk("rsvdiv_res", result, 32'd0);
    chk("rsvdiv_hi", hi, 32'hFFFF_FFFE); chk("rsvdiv_lo", lo, 32'd1); chk("rsvdiv_zero", zero, 1'b0);
    run_op(c_DIVU, 32'd9, 32'd0, 0, n);
    chk("rsvdivu_dbz", dbz, 1'b0); chk("rsvdivu_lo", lo, 32'd1);
`endif
    run_op(c_SUB, 32'h8000_0000, 32'd1, 0, n);
    run_op(c_OR, 32'hF0F0_0000, 32'h0000_0F0F, 0, n);
    run_op(c_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, n);
    run_op(c_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0, n);
    run_op(c_ADD, 32'hFFFF_FFFF, 32'd1, 0, n);
    run_op(c_SLT, 32'd1, 32'hFFFF_FFFF, 0, n);
    run_op(4'd13, 32'd3, 32'd4, 0, n);
    chk("rsv_res", result, 32'd0); chk("rsv_zero", zero, 1'b0);
    run_op(c_MULT, 32'h8000_0000, 32'h8000_0000, 0, n);
    run_op(c_MULTU, 32'd0, 32'h1234_5678, 0, n);
    run_op(c_MULT, 32'hFFFF_FFFB, 32'd7, 0, n);

    // Abort a running multiply with reset; a start pulse mid-run is ignored
    @(negedge clk);
    model_issue(c_MULT, 32'd3, 32'd4);
    start = 1; op = c_MULT; a = 32'd3; b = 32'd4;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = (i == 5);
      op = c_ADD; a = 32'd1; b = 32'd1;
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("arst_busy", busy, 1'b0); chk("arst_done", done, 1'b0);
    chk("arst_result", result, 32'd0); chk("arst_hi", hi, 32'd0); chk("arst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    run_op(c_ADD, 32'd2, 32'd3, 0, n);
    chk("post_rst_lat", n, 1); chk("post_rst_res", result, 32'd5);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
